// File: rtl/cipher128.sv
// cipher128: iterative AES-128 encryption datapath, one round per clock.
// A start pulse captures plaintext and applies round key 0. Rounds 1..10 then
// consume one round key per cycle from the key schedule. The ciphertext is
// presented with a sticky done flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   single-cycle pulse; captures plaintext, applies round key 0
//   plaintext  in   128-bit block, FIPS-197 byte order ([127:120] is byte 0)
//   roundKey   in   round key for the current cycle (key schedule output)
//   busy       out  high while rounds 1..10 are in progress
//   done       out  high after the final round; sticky until reset or start
//   ciphertext out  state register; valid while done is high
module cipher128 #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] roundKey,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    localparam int unsigned BW = 128;
    localparam int unsigned RW = 4;

    // AES S-box; entry x lives at bits [8*(255-x)+7 -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] rnd;
    logic [RW-1:0] rnd_nxt;
    logic [BW-1:0] st;
    logic [BW-1:0] st_nxt;

    logic [BW-1:0] sb_flat;     // SubBytes(st)
    logic [BW-1:0] sr_flat;     // ShiftRows(SubBytes(st))
    logic [BW-1:0] mc_flat;     // MixColumns(ShiftRows(SubBytes(st)))
    logic [BW-1:0] mid_round;
    logic [BW-1:0] last_round;

    // Shared S-box primitive: {~x, 3'b111} == 8*(255-x)+7.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    // Multiply by 2 in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // SubBytes: 16 parallel S-box lookups, byte b at [127-8b -: 8].
    for (genvar b = 0; b < 16; b++) begin : g_sub
        assign sb_flat[BW-1-8*b -: 8] = sbox(st[BW-1-8*b -: 8]);
    end

    // ShiftRows then MixColumns; byte index is 4*col + row.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;

        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates left by r columns.
            assign sr_flat[BW-1-8*(4*c+r) -: 8] = sb_flat[BW-1-8*(4*((c+r)%4)+r) -: 8];
        end

        assign a0 = sr_flat[BW-1-8*(4*c+0) -: 8];
        assign a1 = sr_flat[BW-1-8*(4*c+1) -: 8];
        assign a2 = sr_flat[BW-1-8*(4*c+2) -: 8];
        assign a3 = sr_flat[BW-1-8*(4*c+3) -: 8];

        // Each output byte is {2,3,1,1} rotated against the column.
        assign mc_flat[BW-1-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc_flat[BW-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc_flat[BW-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc_flat[BW-1-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign mid_round  = mc_flat ^ roundKey;
    assign last_round = sr_flat ^ roundKey;

    // State, round counter and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rnd   <= '0;
            st    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            st    <= st_nxt;
            busy  <= (state_nxt == ROUND);
            done  <= (state_nxt == DONE);
        end
    end

    // Next-state and datapath selection; start is only honoured outside ROUND.
    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        st_nxt    = st;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    st_nxt    = plaintext ^ roundKey;
                    rnd_nxt   = RW'(1);
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (rnd == RW'(NR)) begin
                    st_nxt    = last_round;
                    state_nxt = DONE;
                end else begin
                    st_nxt  = mid_round;
                    rnd_nxt = rnd + RW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ciphertext = st;

endmodule

// File: tb/tb_cipher128.sv
`timescale 1ns/1ps
module tb_cipher128;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] roundKey;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q [$];

    // FIPS-197 App. A.1 / B round keys for key 2b7e151628aed2a6abf7158809cf4f3c.
    localparam logic [127:0] RK_B [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    // FIPS-197 App. C.1 round keys for key 000102030405060708090a0b0c0d0e0f.
    localparam logic [127:0] RK_C [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ST0_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ST0_C = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    cipher128 #(.NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .roundKey   (roundKey),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] key_of(input bit use_c, input int r);
        return use_c ? RK_C[r] : RK_B[r];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one block starting at posedge+1; returns at (edge 10)+1, or after an abort.
    task automatic run_block(input bit use_c, input logic [127:0] pt,
                             input logic [127:0] exp0, input logic [127:0] exp_ct,
                             input bit garbage, input int abort_at);
        if (abort_at == 0) exp_q.push_back(exp_ct);
        start     = 1'b1;
        plaintext = pt;
        roundKey  = key_of(use_c, 0);
        @(posedge clk); #1;
        check("st_after_edge0", ciphertext, exp0);
        for (int r = 1; r <= 10; r++) begin
            roundKey = key_of(use_c, r);
            if (garbage && (r == 3 || r == 7)) begin
                start     = 1'b1;
                plaintext = rand128();
            end else begin
                start     = 1'b0;
            end
            check("busy_done_in_round", 128'({busy, done}), 128'b10);
            if (r == abort_at) begin
                #3 reset = 1'b1;
                #1;
                check("abort_flags", 128'({busy, done}), 128'b00);
                check("abort_ct", ciphertext, 128'h0);
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        roundKey  = rand128();
        plaintext = rand128();
        check("busy_done_final", 128'({busy, done}), 128'b01);
    endtask

    // Monitor: pops one expected ciphertext on every rising edge of done.
    initial begin : monitor
        logic prev_done;
        logic [127:0] exp;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got ciphertext %h with empty scoreboard", ciphertext);
                end else begin
                    exp = exp_q.pop_front();
                    check("ciphertext", ciphertext, exp);
                end
            end
            prev_done = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget, got %0t expected < 200000", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset     = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        roundKey  = '0;

        // Reset held with random inputs, including start: outputs stay 0.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start     = 1'($urandom_range(0, 1));
            plaintext = rand128();
            roundKey  = rand128();
            check("reset_flags", 128'({busy, done}), 128'b00);
            check("reset_ct", ciphertext, 128'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;

        // No start: remains idle.
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            plaintext = rand128();
            roundKey  = rand128();
            check("idle_flags", 128'({busy, done}), 128'b00);
            check("idle_ct", ciphertext, 128'h0);
        end

        // App. B plain run.
        run_block(1'b0, PT_B, ST0_B, CT_B, 1'b0, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("done_hold_b", 128'({busy, done}), 128'b01);
        end

        // App. B with ignored starts in rounds 3 and 7, then App. C.1 back-to-back.
        run_block(1'b0, PT_B, ST0_B, CT_B, 1'b1, 0);
        run_block(1'b1, PT_C, ST0_C, CT_C, 1'b0, 0);

        // Sticky done and stable ciphertext under random inputs.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            plaintext = rand128();
            roundKey  = rand128();
            check("sticky_flags", 128'({busy, done}), 128'b01);
            check("sticky_ct", ciphertext, CT_C);
        end

        // Abort during round 5, then a clean App. C.1 run.
        run_block(1'b1, PT_C, ST0_C, CT_C, 1'b0, 5);
        check("post_abort_flags", 128'({busy, done}), 128'b00);
        @(posedge clk); #1;
        run_block(1'b1, PT_C, ST0_C, CT_C, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(exp_q.size()), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
